// File: rtl/input_conditioner_if.sv
// Raw sensor/button inputs, controller acknowledge and conditioned outputs of the input conditioner.
// The slave side is the conditioner; the master side is whatever drives the raw pins and consumes the outputs.
interface input_conditioner_if;
  logic sensor_raw;
  logic walk_raw;
  logic walk_ack;
  logic sensor;
  logic walk;
  logic walk_press;
  logic tick;

  modport master (
    output sensor_raw,
    output walk_raw,
    output walk_ack,
    input  sensor,
    input  walk,
    input  walk_press,
    input  tick
  );

  modport slave (
    input  sensor_raw,
    input  walk_raw,
    input  walk_ack,
    output sensor,
    output walk,
    output walk_press,
    output tick
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise and debounce sensor/button contacts, latch walk requests, and generate a free-running tick.
// Latency: DB_LEN+2 edges to sensor, one more to walk_press; no backpressure, walk holds until walk_ack.
module input_conditioner #(
  parameter int DB_LEN   = 8,
  parameter int TICK_DIV = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input_conditioner_if.slave    io
);

  localparam logic [7:0]  DB_LAST   = 8'(DB_LEN - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  // Channel 0 is the vehicle sensor, channel 1 the pedestrian button.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] stable_q, stable_d;
  logic [7:0] db_cnt_q [2];
  logic [7:0] db_cnt_d [2];
  logic [1:0] mismatch;

  logic        walk_dly_q;
  logic        walk_press_q, walk_press_d;
  logic        walk_q, walk_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;

  assign mismatch = sync2_q ^ stable_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (mismatch[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Rising edge of the debounced button, seen one edge after the stable flip.
  assign walk_press_d = stable_q[1] & ~walk_dly_q;

  // A fresh press outranks a simultaneous acknowledge so it is never lost.
  assign walk_d = walk_press_q | (walk_q & ~io.walk_ack);

  assign tick_cnt_d = (tick_cnt_q == TICK_LAST) ? 16'd0 : tick_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      walk_dly_q   <= 1'b0;
      walk_press_q <= 1'b0;
      walk_q       <= 1'b0;
      tick_cnt_q   <= '0;
    end else begin
      sync1_q      <= {io.walk_raw, io.sensor_raw};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      walk_dly_q   <= stable_q[1];
      walk_press_q <= walk_press_d;
      walk_q       <= walk_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign io.sensor     = stable_q[0];
  assign io.walk       = walk_q;
  assign io.walk_press = walk_press_q;
  assign io.tick       = (tick_cnt_q == TICK_LAST);

endmodule
